// File: rtl/cpu_control_pkg.sv
// rtl/cpu_control_pkg.sv - shared constants, state encoding and instruction classes for cpu_control
package cpu_pkg;

    localparam int W = 16;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [2:0] S_WAIT      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_GET_A     = 3'd2;
    localparam logic [2:0] S_GET_B     = 3'd3;
    localparam logic [2:0] S_ALU       = 3'd4;
    localparam logic [2:0] S_WRITE_RD  = 3'd5;
    localparam logic [2:0] S_WRITE_IMM = 3'd6;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_MOV_IMM,
        CLS_MOV_REG,
        CLS_BINARY,
        CLS_CMP,
        CLS_MVN
    } instr_cls_e;

    typedef struct packed {
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       write;
        logic       asel;
        logic       bsel;
        logic [2:0] readnum;
        logic [2:0] writenum;
    } ctrl_t;

    function automatic instr_cls_e classify(input logic [2:0] opcode, input logic [1:0] op);
        instr_cls_e cls;
        cls = CLS_ILLEGAL;
        if (opcode == OPC_MOV && op == OP_MOV_IMM) begin
            cls = CLS_MOV_IMM;
        end else if (opcode == OPC_MOV && op == OP_MOV_REG) begin
            cls = CLS_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD, OP_AND: cls = CLS_BINARY;
                OP_CMP:         cls = CLS_CMP;
                default:        cls = CLS_MVN;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/cpu_control_if.sv
// rtl/cpu_control_if.sv - instruction input and datapath control bundle (illegal only with CPU_CONTROL_ILLEGAL_TRAP_EN)
interface cpu_control_if;
    import cpu_pkg::*;

    logic         s;
    logic         load;
    logic [W-1:0] in;
    logic         w;
    logic [1:0]   vsel;
    logic         loada;
    logic         loadb;
    logic         loadc;
    logic         loads;
    logic         write;
    logic         asel;
    logic         bsel;
    logic [2:0]   readnum;
    logic [2:0]   writenum;
    logic [1:0]   shift;
    logic [1:0]   ALUop;
    logic [W-1:0] sximm5;
    logic [W-1:0] sximm8;
`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
    logic         illegal;
`endif

    modport master (
        output s, load, in,
        input  w, vsel, loada, loadb, loadc, loads, write, asel, bsel,
        input  readnum, writenum, shift, ALUop, sximm5, sximm8
`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
        , input illegal
`endif
    );

    modport slave (
        input  s, load, in,
        output w, vsel, loada, loadb, loadc, loads, write, asel, bsel,
        output readnum, writenum, shift, ALUop, sximm5, sximm8
`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
        , output illegal
`endif
    );

endinterface

// File: rtl/cpu_control_instr_dec.sv
// rtl/cpu_control_instr_dec.sv - combinational instruction field extraction and immediate sign extension
module instr_dec
    import cpu_pkg::*;
(
    input  logic [W-1:0] ir_i,
    output logic [1:0]   op_o,
    output logic [2:0]   rn_o,
    output logic [2:0]   rd_o,
    output logic [1:0]   sh_o,
    output logic [2:0]   rm_o,
    output logic [W-1:0] sximm5_o,
    output logic [W-1:0] sximm8_o,
    output instr_cls_e   cls_o
);

    assign op_o     = ir_i[12:11];
    assign rn_o     = ir_i[10:8];
    assign rd_o     = ir_i[7:5];
    assign sh_o     = ir_i[4:3];
    assign rm_o     = ir_i[2:0];
    assign sximm5_o = {{(W-5){ir_i[4]}}, ir_i[4:0]};
    assign sximm8_o = {{(W-8){ir_i[7]}}, ir_i[7:0]};
    assign cls_o    = classify(ir_i[15:13], ir_i[12:11]);

endmodule

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - Moore FSM controller for the 16-bit datapath; optional trap via CPU_CONTROL_ILLEGAL_TRAP_EN
module cpu_control
    import cpu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    cpu_control_if.slave  bus
);

    logic [2:0]   state_q, state_d;
    logic [W-1:0] ir_q;
    logic         ir_load;
    logic         start_blocked;
    ctrl_t        ctrl;

    logic [1:0]   op;
    logic [2:0]   rn, rd, rm;
    logic [1:0]   sh;
    logic [W-1:0] sximm5, sximm8;
    instr_cls_e   cls;

    instr_dec u_dec (
        .ir_i     (ir_q),
        .op_o     (op),
        .rn_o     (rn),
        .rd_o     (rd),
        .sh_o     (sh),
        .rm_o     (rm),
        .sximm5_o (sximm5),
        .sximm8_o (sximm8),
        .cls_o    (cls)
    );

    // IR only moves while idle, so cls is stable for the whole instruction
    assign ir_load = bus.load && (state_q == S_WAIT);

`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else if (state_q == S_DECODE && cls == CLS_ILLEGAL) begin
            illegal_q <= 1'b1;
        end
    end

    assign start_blocked = illegal_q;
    assign bus.illegal   = illegal_q;
`else
    assign start_blocked = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ir_load) begin
                ir_q <= bus.in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (bus.s && !start_blocked) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (cls)
                    CLS_MOV_IMM:          state_d = S_WRITE_IMM;
                    CLS_BINARY, CLS_CMP:  state_d = S_GET_A;
                    CLS_MOV_REG, CLS_MVN: state_d = S_GET_B;
                    default:              state_d = S_WAIT;
                endcase
            end
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_ALU;
            S_ALU:       state_d = (cls == CLS_CMP) ? S_WAIT : S_WRITE_RD;
            S_WRITE_RD:  state_d = S_WAIT;
            S_WRITE_IMM: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_GET_A: begin
                ctrl.readnum = rn;
                ctrl.loada   = 1'b1;
            end
            S_GET_B: begin
                ctrl.readnum = rm;
                ctrl.loadb   = 1'b1;
            end
            S_ALU: begin
                // MOV-reg and MVN ignore Ain, so feed zero instead of a stale A
                ctrl.asel  = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
                ctrl.loads = (cls == CLS_CMP);
                ctrl.loadc = (cls != CLS_CMP);
            end
            S_WRITE_RD: begin
                ctrl.writenum = rd;
                ctrl.vsel     = VSEL_C;
                ctrl.write    = 1'b1;
            end
            S_WRITE_IMM: begin
                ctrl.writenum = rn;
                ctrl.vsel     = VSEL_IMM8;
                ctrl.write    = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign bus.w        = (state_q == S_WAIT);
    assign bus.vsel     = ctrl.vsel;
    assign bus.loada    = ctrl.loada;
    assign bus.loadb    = ctrl.loadb;
    assign bus.loadc    = ctrl.loadc;
    assign bus.loads    = ctrl.loads;
    assign bus.write    = ctrl.write;
    assign bus.asel     = ctrl.asel;
    assign bus.bsel     = ctrl.bsel;
    assign bus.readnum  = ctrl.readnum;
    assign bus.writenum = ctrl.writenum;
    // MOV-reg encodes op=00, so passing op through gives the required ALUop=00
    assign bus.shift    = sh;
    assign bus.ALUop    = op;
    assign bus.sximm5   = sximm5;
    assign bus.sximm8   = sximm8;

endmodule

// File: tb/tb_cpu_control.sv
// tb/tb_cpu_control.sv - randomized self-checking bench for cpu_control against a phase-list model
module tb_cpu_control;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cpu_control_if bus();

    cpu_control #(.W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic       w;
        logic [1:0] vsel;
        logic       loada, loadb, loadc, loads, write, asel, bsel;
        logic [2:0] readnum, writenum;
    } obs_t;

    obs_t        q[$];
    logic [15:0] mir;
    logic        mill, ill_pend;
    logic        chk_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    function automatic obs_t idle_obs();
        obs_t e;
        e   = '0;
        e.w = 1'b1;
        return e;
    endfunction

    // The instruction is a list of per-cycle expected outputs, DECODE first
    task automatic start_instr(input logic [15:0] ir);
        obs_t e;
        logic [2:0] opc;
        logic [1:0] op;
        logic unary;
        opc = ir[15:13];
        op  = ir[12:11];
        e = '0;
        q.push_back(e);
        if (opc == 3'b110 && op == 2'b10) begin
            e.write = 1'b1; e.writenum = ir[10:8]; e.vsel = 2'b10;
            q.push_back(e);
        end else if (opc == 3'b101 || (opc == 3'b110 && op == 2'b00)) begin
            unary = (opc == 3'b110) || (op == 2'b11);
            if (!unary) begin
                e = '0; e.loada = 1'b1; e.readnum = ir[10:8];
                q.push_back(e);
            end
            e = '0; e.loadb = 1'b1; e.readnum = ir[2:0];
            q.push_back(e);
            e = '0;
            if (opc == 3'b101 && op == 2'b01) begin
                e.loads = 1'b1;
                q.push_back(e);
            end else begin
                e.loadc = 1'b1; e.asel = unary;
                q.push_back(e);
                e = '0; e.write = 1'b1; e.writenum = ir[7:5];
                q.push_back(e);
            end
        end else begin
`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
            ill_pend = 1'b1;
`endif
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            mir = 16'h0000;
            mill = 1'b0;
            ill_pend = 1'b0;
        end else if (q.size() != 0) begin
            q.delete(0);
            if (q.size() == 0 && ill_pend) begin
                mill = 1'b1;
                ill_pend = 1'b0;
            end
        end else begin
            if (bus.load) mir = bus.in;
            if (bus.s && !mill) start_instr(mir);
        end
    end

    always @(negedge clk) begin
        obs_t act, exp_o;
        logic [15:0] e5, e8;
        if (reset_n && chk_en) begin
            exp_o = (q.size() != 0) ? q[0] : idle_obs();
            act.w = bus.w; act.vsel = bus.vsel; act.loada = bus.loada; act.loadb = bus.loadb;
            act.loadc = bus.loadc; act.loads = bus.loads; act.write = bus.write;
            act.asel = bus.asel; act.bsel = bus.bsel; act.readnum = bus.readnum;
            act.writenum = bus.writenum;
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("FAIL ctrl t=%0t got %h want %h", $time, act, exp_o);
            end
            e5 = 16'($signed(mir[4:0]));
            e8 = 16'($signed(mir[7:0]));
            checks++;
            if (bus.shift !== mir[4:3] || bus.ALUop !== mir[12:11] || bus.sximm5 !== e5 || bus.sximm8 !== e8) begin
                errors++;
                $display("FAIL irfields t=%0t got %h/%h/%h/%h want %h/%h/%h/%h", $time,
                         bus.shift, bus.ALUop, bus.sximm5, bus.sximm8, mir[4:3], mir[12:11], e5, e8);
            end
`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
            checks++;
            if (bus.illegal !== mill) begin
                errors++;
                $display("FAIL illegal t=%0t got %b want %b", $time, bus.illegal, mill);
            end
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp_v);
        end
    endtask

    int lat, wr, ls;

    task automatic run_instr(input logic [15:0] word);
        @(negedge clk);
        bus.in = word; bus.load = 1'b1; bus.s = 1'b1;
        @(posedge clk);
        lat = 1; wr = -1; ls = 0;
        @(negedge clk);
        bus.s = 1'b0; bus.load = 1'b0;
        while (bus.w !== 1'b1 && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.write === 1'b1 && bus.w === 1'b0) wr = int'(bus.writenum);
            if (bus.loads === 1'b1) ls = 1;
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] v;
        int r;
        v = 16'($urandom);
        r = $urandom_range(0, 7);
        if (r < 3) v[15:13] = 3'b110;
        else if (r < 6) v[15:13] = 3'b101;
`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
        if (!(v[15:13] == 3'b101 || (v[15:13] == 3'b110 && !v[11]))) v[15:11] = 5'b11010;
`endif
        return v;
    endfunction

    initial begin
        bus.s = 1'b0; bus.load = 1'b0; bus.in = 16'h0000;
        #1;
        check("reset_w_async", {31'd0, bus.w}, 32'd1);
        check("reset_enables", {27'd0, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        chk_en = 1'b1;

        run_instr(16'hD007);
        check("movimm_lat", lat, 3);
        check("movimm_wr", wr, 0);
        check("movimm_sximm8", {16'd0, bus.sximm8}, 32'h0007);
        run_instr(16'hA140);
        check("add_lat", lat, 6);
        check("add_wr", wr, 2);
        run_instr(16'hA900);
        check("cmp_lat", lat, 5);
        check("cmp_nowrite", wr, -1);
        check("cmp_loads", ls, 1);
        run_instr(16'hB860);
        check("mvn_lat", lat, 5);
        check("mvn_wr", wr, 3);
        run_instr(16'hC089);
        check("movreg_lat", lat, 5);
        check("movreg_wr", wr, 4);
        check("movreg_shift", {30'd0, bus.shift}, 32'd1);

        @(negedge clk);
        bus.in = 16'hA140; bus.load = 1'b1; bus.s = 1'b1;
        @(negedge clk);
        bus.s = 1'b0; bus.in = 16'hFFFF;
        repeat (3) @(negedge clk);
        bus.load = 1'b0;
        lat = 0;
        while (bus.w !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        check("midload_done", {31'd0, bus.w}, 32'd1);
        check("midload_ir", {16'd0, bus.sximm8}, 32'h0040);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.s = ($urandom_range(0, 3) == 0);
            bus.load = $urandom_range(0, 1) == 1;
            bus.in = rand_word();
        end
        @(negedge clk);
        bus.s = 1'b0; bus.load = 1'b0;
        lat = 0;
        while (bus.w !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end

        @(negedge clk);
        bus.in = 16'hA140; bus.load = 1'b1; bus.s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.s = 1'b0; bus.load = 1'b0;
        @(posedge clk); @(posedge clk);
        #2;
        check("getb_loadb", {31'd0, bus.loadb}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("midreset_w", {31'd0, bus.w}, 32'd1);
        check("midreset_loadb", {31'd0, bus.loadb}, 32'd0);
        check("midreset_write", {31'd0, bus.write}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("postreset_ir", {16'd0, bus.sximm8}, 32'h0000);
        check("postreset_w", {31'd0, bus.w}, 32'd1);

        run_instr(16'hE000);
        check("nop_lat", lat, 2);
        check("nop_nowrite", wr, -1);
`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
        check("trap_set", {31'd0, bus.illegal}, 32'd1);
        @(negedge clk);
        bus.in = 16'hD007; bus.load = 1'b1; bus.s = 1'b1;
        repeat (4) @(negedge clk);
        check("trap_w_held", {31'd0, bus.w}, 32'd1);
        bus.s = 1'b0; bus.load = 1'b0;
`endif
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
Controller for the 16-bit datapath (register file, shifter, ALU, status). It holds the instruction register and decodes the instruction fields. A Moore FSM drives every datapath control input (vsel, loada, loadb, asel, bsel, loadc, loads, write, readnum, writenum, shift, ALUop, sximm5, sximm8) to execute MOV/ADD/CMP/AND/MVN, then returns to a wait state with w=1.

Parameters:
- W, 16, instruction/immediate width (fixed ISA; only 16 supported)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- s  in  1  start; sampled only in WAIT
- load  in  1  load instruction register from `in`; honoured only while w=1
- in  in  16  instruction word
- w  out  1  1 = idle in WAIT
- vsel  out  2  00=C, 01=PC, 10=sximm8, 11=mdata
- loada, loadb, loadc, loads, write  out  1 each  datapath enables
- asel  out  1  1 selects 0 for Ain
- bsel  out  1  1 selects sximm5 for Bin
- readnum, writenum  out  3 each  register selects
- shift  out  2  IR[4:3]
- ALUop  out  2  IR[12:11]
- sximm5  out  16  sign-extended IR[4:0]
- sximm8  out  16  sign-extended IR[7:0]

Behaviour:
- Instruction fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Opcode 110 op 10 is MOV Rn,#imm8. Opcode 110 op 00 is MOV Rd,Rm{sh}. Opcode 101 op 00/01/10/11 is ADD/CMP/AND/MVN.
- IR: 16-bit register, cleared to 0 on reset. It loads `in` on a clock edge when load=1 and state=WAIT. load in any other state is ignored.
- States and transitions:
  - WAIT: w=1. Goes to DECODE when s=1.
  - DECODE: no enables. MOV-imm goes to WRITE_IMM. ADD/CMP/AND go to GET_A. MOV-reg/MVN go to GET_B. Illegal goes to WAIT.
  - GET_A: readnum=Rn, loada=1. Goes to GET_B.
  - GET_B: readnum=Rm, loadb=1. Goes to ALU.
  - ALU: loadc=1. asel=1 for MOV-reg/MVN, else 0. bsel=0. ALUop=op, except MOV-reg forces ALUop=00 (0+sh(Rm)). CMP asserts loads=1 and loadc=0, then goes to WAIT. All others go to WRITE_RD.
  - WRITE_RD: writenum=Rd, vsel=00, write=1. Goes to WAIT.
  - WRITE_IMM: writenum=Rn, vsel=10, write=1. Goes to WAIT.
- Outputs are decoded from state and IR only (Moore); s and load do not reach outputs combinationally.
- Outside the listed assertions, every enable is 0, vsel=00, asel=0, bsel=0, and readnum=writenum=000.
- shift, ALUop, sximm5 and sximm8 follow IR at all times.
- Latency, counted in rising edges from the edge that samples s=1 until w=1:
  - MOV-imm: 3
  - MOV-reg/MVN: 5
  - CMP: 5
  - ADD/AND: 6
- Reset (async): state goes to WAIT and IR to 0 immediately. w=1 and all enables=0 without waiting for a clock, including mid-instruction; no partial write occurs.
- s=1 and load=1 in the same WAIT cycle: IR captures the new word and DECODE uses the new IR.
- s held high: the FSM re-enters DECODE on the edge after returning to WAIT.
- s is ignored outside WAIT.

Optional Feature:
- Macro: CPU_CONTROL_ILLEGAL_TRAP_EN.
- Enabled:
  - Adds output `illegal` (1 bit), reset to 0.
  - `illegal` is set in DECODE for any opcode/op not listed above and is sticky until reset.
  - While `illegal`=1, s is ignored and w stays 1.
- Disabled: illegal encodings behave as a NOP (DECODE to WAIT, 2 edges) and the port is absent.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants OPC_MOV=110, OPC_ALU=101
  - op constants
  - vsel codes VSEL_C/VSEL_PC/VSEL_IMM8/VSEL_MDATA
  - state encoding (7 states, binary)
- Sub-module instr_dec: combinational field extraction and sign extension (sximm5/sximm8, Rn/Rd/Rm/sh/op/opcode) from the IR. The FSM stays in cpu_control.

Test Plan:
- Reset mid-GET_B with reset_n=0, no clock → w=1 and loadb=0 immediately. After release, IR=0x0000 and the FSM is in WAIT.
- load 0xD007 (MOV R0,#7), pulse s → WRITE_IMM asserts write=1, writenum=0, vsel=10, sximm8=0x0007. w=1 after 3 edges.
- load 0xA140 (ADD R2,R1,R0) → readnum 1 with loada, then readnum 0 with loadb, then loadc with ALUop=00, asel=0, then write with writenum=2, vsel=00. w returns after 6 edges.
- load 0xA900 (CMP R1,R0) → loads=1 and loadc=0 in ALU, no write cycle, w after 5 edges.
- load 0xB860 (MVN R3,R0) and 0xC089 (MOV R4,R1,LSL#1) → GET_A skipped, asel=1, shift=00/01, ALUop=11/00. Writes R3 and R4 respectively.
- load asserted mid-ADD with 0xFFFF → IR unchanged. Load 0xE000 in WAIT + s → NOP (macro off), or `illegal`=1 and further s ignored (macro on).
